// File: rtl/cache_pkg.sv
// Shared cache definitions: write-back FSM states, word width, default
// line geometry and the line-address compare used by both the victim
// buffer lookup and the cache tag path.
package cache_pkg;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wb_state_e;

   localparam int WORD_W         = 32;
   localparam int LINE_WORDS_DEF = 4;
   localparam int LINE_OFF_W     = $clog2(LINE_WORDS_DEF * 4);
   localparam int BEAT_W         = $clog2(LINE_WORDS_DEF);

   // True when two byte addresses fall in the same line. Addresses are
   // zero-extended to 64 bits by the caller so one helper serves any width.
   function automatic logic line_match(input logic [63:0] a,
                                       input logic [63:0] b,
                                       input int unsigned off_w);
      return (a >> off_w) == (b >> off_w);
   endfunction

endpackage

// File: rtl/victim_wb_buffer.sv
// victim_wb_buffer: single-entry write-back buffer for dirty victim lines.
// Accepts one evicted line, then drains it as an address phase,
// LINE_WORDS data beats and a write response.
//
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   push_valid/ready/addr/data   victim line from the replacement logic
//   aw_valid/ready/addr/len      write address channel
//   w_valid/ready/data/strb/last write data channel
//   b_valid/ready                write response channel (code ignored)
//   lk_addr/lk_hit/lk_data       lookup of the buffered line
//   busy                         entry occupied
//
// Build option: VICTIM_BYPASS_EN builds the lookup comparator and word mux;
// without it lk_hit/lk_data are tied to 0 and the cache must stall misses
// to the victim line while busy is high.
import cache_pkg::*;

module victim_wb_buffer #(
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push_valid,
   output logic                       push_ready,
   input  logic [ADDR_W-1:0]          push_addr,
   input  logic [LINE_WORDS*32-1:0]   push_data,
   output logic                       aw_valid,
   input  logic                       aw_ready,
   output logic [ADDR_W-1:0]          aw_addr,
   output logic [7:0]                 aw_len,
   output logic                       w_valid,
   input  logic                       w_ready,
   output logic [31:0]                w_data,
   output logic [3:0]                 w_strb,
   output logic                       w_last,
   input  logic                       b_valid,
   output logic                       b_ready,
   input  logic [ADDR_W-1:0]          lk_addr,
   output logic                       lk_hit,
   output logic [31:0]                lk_data,
   output logic                       busy
);

   localparam int L_OFF_W  = $clog2(LINE_WORDS * 4);
   localparam int L_BEAT_W = $clog2(LINE_WORDS);
   localparam logic [L_BEAT_W-1:0] LAST_BEAT = L_BEAT_W'(LINE_WORDS - 1);
   localparam logic [L_BEAT_W-1:0] PENULT    = L_BEAT_W'(LINE_WORDS - 2);

   wb_state_e                          state;
   logic [L_BEAT_W-1:0]                cnt;
   logic [ADDR_W-1:0]                  line_addr;
   logic [LINE_WORDS-1:0][WORD_W-1:0]  line_data;

   // Offset bits of the pushed address are forced to zero on capture.
   logic unused_push;
   assign unused_push = ^push_addr[L_OFF_W-1:0];

   assign aw_addr = line_addr;
   assign aw_len  = 8'(LINE_WORDS - 1);
   assign w_data  = line_data[cnt];
   assign w_strb  = 4'hf;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         push_ready <= 1'b1;
         aw_valid   <= 1'b0;
         w_valid    <= 1'b0;
         w_last     <= 1'b0;
         b_ready    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (push_valid) begin
               line_addr  <= {push_addr[ADDR_W-1:L_OFF_W], L_OFF_W'(0)};
               line_data  <= push_data;
               busy       <= 1'b1;
               push_ready <= 1'b0;
               aw_valid   <= 1'b1;
               state      <= ADDR;
            end
            ADDR: if (aw_ready) begin
               aw_valid <= 1'b0;
               w_valid  <= 1'b1;
               cnt      <= '0;
               w_last   <= (LINE_WORDS == 1);
               state    <= DATA;
            end
            DATA: if (w_ready) begin
               if (cnt == LAST_BEAT) begin
                  w_valid <= 1'b0;
                  w_last  <= 1'b0;
                  b_ready <= 1'b1;
                  cnt     <= '0;
                  state   <= RESP;
               end else begin
                  cnt    <= cnt + 1'b1;
                  // w_last is registered, so it is set one beat ahead
                  w_last <= (cnt == PENULT);
               end
            end
            RESP: if (b_valid) begin
               b_ready    <= 1'b0;
               busy       <= 1'b0;
               push_ready <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef VICTIM_BYPASS_EN
   logic [L_BEAT_W-1:0] lk_word;
   logic                unused_lk;
   assign unused_lk = ^lk_addr[1:0];
   assign lk_word   = lk_addr[L_OFF_W-1:2];
   assign lk_hit    = busy && (state != IDLE) &&
                      line_match(64'(lk_addr), 64'(line_addr), L_OFF_W);
   assign lk_data   = lk_hit ? line_data[lk_word] : '0;
`else
   logic unused_lk;
   assign unused_lk = ^lk_addr;
   assign lk_hit    = 1'b0;
   assign lk_data   = '0;
`endif

endmodule

// File: doc/victim_wb_buffer.md
Name: victim_wb_buffer

Overview:
- Single-entry write-back buffer that sits directly downstream of the cache replacement selector.
- When the replacement logic flags a dirty victim, the cache pushes the whole evicted line here.
- The block drains the line to memory as an address phase, LINE_WORDS data beats and a write response, so the refill can proceed without waiting for the write-back.
- Provides an address-match lookup so reads to the line being evicted are not lost.

Parameters:
- LINE_WORDS, 4, 32-bit words per cache line; power of two, 2..16.
- ADDR_W, 32, byte-address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- push_valid  in  1  victim line offered.
- push_ready  out  1  buffer can accept a line.
- push_addr  in  ADDR_W  victim line base address; low log2(LINE_WORDS*4) bits ignored and treated as zero.
- push_data  in  LINE_WORDS*32  line data; word i = push_data[i*32 +: 32].
- aw_valid  out  1  write address valid.
- aw_ready  in  1  memory accepts address.
- aw_addr  out  ADDR_W  line base address, offset bits zero.
- aw_len  out  8  LINE_WORDS-1.
- w_valid  out  1  write beat valid.
- w_ready  in  1  memory accepts beat.
- w_data  out  32  beat data.
- w_strb  out  4  always 4'hf.
- w_last  out  1  final beat.
- b_valid  in  1  write response.
- b_ready  out  1  response accepted.
- lk_addr  in  ADDR_W  lookup byte address.
- lk_hit  out  1  lookup matches the buffered line.
- lk_data  out  32  buffered word selected by lk_addr word offset.
- busy  out  1  entry occupied.

Behaviour:
- One clock; reset is synchronous and active-high. The clock and reset ports are named clock and reset.
- FSM states: IDLE, ADDR, DATA, RESP.
- Reset:
  - state goes to IDLE; beat counter 0; entry invalid.
  - aw_valid, w_valid, w_last, b_ready, busy and lk_hit are 0.
  - push_ready is 1 from the first cycle after reset.
  - A reset asserted mid-drain discards the entry with no further bus activity. Any outstanding response is ignored.
- IDLE:
  - push_ready = 1.
  - On push_valid, latch addr (offset zeroed) and data, set busy, and go to ADDR.
  - aw_valid rises the cycle after the push: push at cycle T gives aw_valid at T+1.
- ADDR:
  - aw_valid = 1; aw_addr and aw_len are stable until aw_ready.
  - On aw_ready, go to DATA with the beat counter at 0.
- DATA:
  - w_valid = 1; w_data = word[cnt]; w_last = (cnt == LINE_WORDS-1).
  - The counter advances only on w_ready.
  - A handshake on the last beat goes to RESP; the counter wraps to 0.
  - Beats are never issued before the address handshake.
  - With w_ready held high, the data phase takes exactly LINE_WORDS cycles.
- RESP:
  - b_ready = 1.
  - On b_valid, clear the entry and go to IDLE; busy falls the next cycle.
  - The response code is ignored.
- push_ready is 0 in every state except IDLE. A push offered in the same cycle as the b handshake is not accepted; it is accepted one cycle later.
- All outputs are registered-state driven; there are no combinational paths from aw_ready, w_ready or b_valid to outputs.
- Lookup: compare lk_addr line bits with the entry address, combinational.
  - lk_hit = busy && match, in states ADDR, DATA and RESP.
  - In IDLE, lk_hit = 0.
- lk_data is the selected word when lk_hit is 1, and 0 otherwise.

Optional Feature:
- Macro: VICTIM_BYPASS_EN.
- Defined: lk_hit and lk_data behave as described above; the cache may serve a read from the buffer.
- Undefined:
  - lk_hit is constant 0 and lk_data is constant 0; the lookup comparator and mux are not built.
  - The cache must stall a miss on the victim address while busy = 1.

Decomposition:
- Shared package cache_pkg:
  - FSM state enum (IDLE/ADDR/DATA/RESP).
  - WORD_W = 32.
  - LINE_OFF_W = log2(LINE_WORDS*4).
  - BEAT_W = log2(LINE_WORDS).
- The line-address compare function lives in cache_pkg for reuse by the cache tag path.
- No sub-module; the beat counter and word mux stay inline.

Test Plan:
1. Reset, then push addr 0x1000_0014 with data words 0x11,0x22,0x33,0x44; hold aw_ready, w_ready and b_valid at 1 -> aw_addr 0x1000_0010 at T+1, beats 0x11..0x44 on consecutive cycles, w_last only on 0x44, push_ready 1 again 1 cycle after b.
2. Apply random backpressure, with w_ready low for 3 cycles on beat 2 -> w_data holds 0x33 steady, no beat skipped or duplicated, exactly 4 handshakes.
3. Second push offered while in DATA -> push_ready 0 and the push is not taken; after b, the push completes with its own address.
4. VICTIM_BYPASS_EN defined, lk_addr 0x1000_0018 during RESP -> lk_hit 1, lk_data 0x33. lk_addr 0x1000_0020 -> lk_hit 0. Macro undefined -> lk_hit always 0.
5. Assert reset in DATA after beat 1 -> next cycle all valids 0, busy 0, push_ready 1; a stale b_valid afterwards is ignored.
6. Push with b_valid delayed 10 cycles -> b_ready held 1 throughout RESP, busy 1 until the b handshake.
